// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by the transmitter (and its receive-side
//   counterpart).
//   - tx_state_t : transmitter frame state.
//   - baud_div() : clocks per bit, rounded to nearest.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Rounded-to-nearest number of system clocks per line bit.
  function automatic int baud_div(input int clock_rate, input int baud_rate);
    return (clock_rate + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-period timer. Counts down from DIV-1 to 0, pulses o_bit_end for the
//   single cycle the count is 0, then reloads. i_restart reloads the counter
//   synchronously so a new frame's first bit gets a full DIV cycles.
// Ports
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset (count cleared to 0)
//   i_restart  in  reload the counter to DIV-1 on this edge
//   o_bit_end  out high in the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_restart || (r_count == '0)) begin
      r_count <= CW'(DIV - 1);
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_bit_end = (r_count == '0);

endmodule

// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
//   System-clock UART transmitter with a valid/ready byte interface.
//   Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit,
//   STOP_BITS stop bits; every bit lasts DIV = round(CLOCK_RATE/BAUD_RATE)
//   clocks. The bit timer restarts at each acceptance.
//
//   Optional feature macro: UART_PARITY_EN
//     defined   : a parity bit follows the data (even, or odd if PARITY_ODD=1)
//     undefined : no parity bit; PARITY_ODD is ignored
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset; abandons any frame
//   data   in   byte to send, sampled only on acceptance
//   valid  in   producer has data
//   ready  out  transmitter can accept this cycle (IDLE, or last stop cycle)
//   tx     out  registered serial line, idles high
//   idle   out  high when no frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  idle
);

  localparam int DIV     = baud_div(CLOCK_RATE, BAUD_RATE);
  localparam int BIT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int CNT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  // Elaboration-time parameter sanity checks.
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_stream: DIV=%0d must be at least 2", DIV);
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_stream: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity
    $error("uart_tx_stream: PARITY_ODD=%0d must be 0 or 1", PARITY_ODD);
  end

  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_tx;
  logic                  r_idle;
`ifdef UART_PARITY_EN
  logic                  r_parity;
`endif

  logic w_bit_end;
  logic w_last_stop;
  logic w_ready;
  logic w_accept;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_restart(w_accept),
    .o_bit_end(w_bit_end)
  );

  // Final cycle of the last stop bit: the only in-frame cycle that can accept,
  // which is what gives back-to-back frames with no idle gap.
  assign w_last_stop = (r_state == STOP) &&
                       (r_bit_cnt == CNT_W'(STOP_BITS - 1)) && w_bit_end;

  // NOTE: ready is decoded from registered state and the bit timer only; it
  // never looks at valid, so there is no combinational valid->ready path.
  assign w_ready  = (r_state == IDLE) || w_last_stop;
  assign w_accept = valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_idle    <= 1'b1;
`ifdef UART_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_accept) begin
      // Start bit goes out on the accept edge itself.
      r_state   <= START;
      r_shift   <= data;
      r_bit_cnt <= '0;
      r_tx      <= 1'b0;
      r_idle    <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity  <= (^data) ^ (PARITY_ODD != 0);
`endif
    end else if (w_bit_end) begin
      case (r_state)
        START: begin
          r_state   <= DATA;
          r_tx      <= r_shift[0];
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= '0;
        end
        DATA: begin
          if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            r_bit_cnt <= '0;
`ifdef UART_PARITY_EN
            r_state   <= PARITY;
            r_tx      <= r_parity;
`else
            r_state   <= STOP;
            r_tx      <= 1'b1;
`endif
          end else begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          r_state   <= STOP;
          r_tx      <= 1'b1;
          r_bit_cnt <= '0;
        end
        STOP: begin
          if (r_bit_cnt == CNT_W'(STOP_BITS - 1)) begin
            r_state <= IDLE;
            r_idle  <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: begin
          // IDLE: the free-running bit timer is ignored until acceptance.
        end
      endcase
    end
  end

  assign ready = w_ready;
  assign tx    = r_tx;
  assign idle  = r_idle;

endmodule

// File: tb/tb_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_stream
//   Self-checking bench for uart_tx_stream at default parameters (DIV = 10).
//   The reference model describes a frame as a list of line bits (start, data
//   LSB first, optional parity, stop) and expects bit k/DIV during cycle k
//   after the accept edge. Outputs are sampled on the falling clock edge.
//   Build with +define+UART_PARITY_EN to exercise the parity frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_stream;

  localparam int CLOCK_RATE = 100_000;
  localparam int BAUD_RATE  = 9600;
  localparam int PARITY_ODD = 0;
  localparam int DIV        = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + 8 + P + 1;
  localparam int F     = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       idle;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int acc_cyc[$];

  uart_tx_stream #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(8),
    .STOP_BITS (1),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .idle (idle)
  );

  always #5 clk = ~clk;

  // Accept monitor: counts handshakes and records the cycle of each.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && valid && ready) begin
      n_acc <= n_acc + 1;
      acc_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line bit idx of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (P == 1 && idx == 9) return (^b) ^ (PARITY_ODD != 0);
    return 1'b1;
  endfunction

  // Offer b and wait (bounded) for the accept edge; returns just after it.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    while (!ready && n < 4 * F) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'd0, ready}, 32'd1);
    @(posedge clk);
  endtask

  // Check one whole frame, starting just after its accept edge.
  // hold: keep valid high and present next_b in the last cycle.
  // poke_k: cycle at which data/valid are disturbed for one cycle (-1 none).
  task automatic run_frame(input logic [7:0] b, input bit hold, input logic [7:0] next_b,
                           input int poke_k, input logic [7:0] poke_b);
    logic [7:0] rx = '0;
    for (int k = 0; k < F; k++) begin
      @(negedge clk);
      check("frame_tx", {31'd0, tx}, {31'd0, frame_bit(b, k / DIV)});
      check("frame_idle", {31'd0, idle}, 32'd0);
      check("frame_ready", {31'd0, ready}, (k == F - 1) ? 32'd1 : 32'd0);
      if ((k % DIV) == DIV / 2 && (k / DIV) >= 1 && (k / DIV) <= 8)
        rx[(k / DIV) - 1] = tx;
      if (k == 0 && !hold) valid = 1'b0;
      if (k == poke_k) begin
        data  = poke_b;
        valid = 1'b1;
      end
      if (poke_k >= 0 && k == poke_k + 1) valid = 1'b0;
      if (k == F - 1 && hold) data = next_b;
    end
    check("rx_byte", {24'd0, rx}, {24'd0, b});
  endtask

  task automatic expect_idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check("idle_tx", {31'd0, tx}, 32'd1);
      check("idle_idle", {31'd0, idle}, 32'd1);
      check("idle_ready", {31'd0, ready}, 32'd1);
    end
  endtask

  initial begin
    string      msg;
    logic [7:0] b;
    logic [7:0] b2;
    int         n0;

    // 1. Reset and quiet line.
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_idle", {31'd0, idle}, 32'd1);
    rst_n = 1'b1;
    expect_idle(1000);

    // 2. Single byte 8'h48 with a one-cycle valid pulse.
    send(8'h48);
    run_frame(8'h48, 1'b0, 8'h00, -1, 8'h00);
    @(negedge clk);
    check("h48_idle_after", {31'd0, idle}, 32'd1);
    check("h48_ready_after", {31'd0, ready}, 32'd1);
    check("h48_tx_after", {31'd0, tx}, 32'd1);

    // 3. Back-to-back "Hello World! " with valid held high.
    msg = "Hello World! ";
    expect_idle(5);
    n0 = n_acc;
    acc_cyc.delete();
    send(msg[0]);
    for (int i = 0; i < 13; i++) begin
      if (i < 12) begin
        run_frame(msg[i], 1'b1, msg[i+1], -1, 8'h00);
        @(posedge clk);
      end else begin
        run_frame(msg[i], 1'b0, 8'h00, -1, 8'h00);
      end
    end
    @(negedge clk);
    check("hello_idle_end", {31'd0, idle}, 32'd1);
    check("hello_accepts", n_acc - n0, 32'd13);
    if (acc_cyc.size() == 13)
      check("hello_span", acc_cyc[12] - acc_cyc[0] + F, 32'd1300);
    else
      check("hello_accept_log", acc_cyc.size(), 32'd13);

    // 4. Asynchronous reset at cycle 45 of a random frame.
    b = 8'($urandom_range(0, 255));
    send(b);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
      check("pre_rst_tx", {31'd0, tx}, {31'd0, frame_bit(b, k / DIV)});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_idle", {31'd0, idle}, 32'd1);
    check("async_rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle(3);
    b = 8'($urandom_range(0, 255));
    send(b);
    run_frame(b, 1'b0, 8'h00, -1, 8'h00);

    // 5. Data changed and valid pulsed while busy: no effect, no extra frame.
    expect_idle(2);
    n0 = n_acc;
    b  = 8'($urandom_range(0, 255));
    b2 = ~b;
    send(b);
    run_frame(b, 1'b0, 8'h00, 30, b2);
    expect_idle(2 * F);
    check("no_extra_frame", n_acc - n0, 32'd1);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 4; i++) begin
      expect_idle(int'($urandom_range(1, 20)));
      b = 8'($urandom_range(0, 255));
      send(b);
      run_frame(b, 1'b0, 8'h00, -1, 8'h00);
    end

`ifdef UART_PARITY_EN
    // 6. Parity frame for 8'h07 (110 cycles at defaults).
    expect_idle(2);
    send(8'h07);
    run_frame(8'h07, 1'b0, 8'h00, -1, 8'h00);
    check("parity_frame_len", F, 32'd110);
    @(negedge clk);
    check("parity_idle_after", {31'd0, idle}, 32'd1);
`endif

    expect_idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
